// File: rtl/sd_block_rx.sv
// sd_block_rx: SPI-mode SD single-block read receiver.
// Waits for the FE start token, receives 512 data bytes and 2 CRC bytes,
// then pulses done. sdclk is produced from clk by a CLK_DIV half-period divider.
// Optional feature: define SD_RX_CRC16_EN to check CRC16-CCITT over the data
// bytes. Without it, crc_err is tied low and the CRC bytes are dropped.
module sd_block_rx #(
  parameter int CLK_DIV       = 2,
  parameter int TOKEN_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       sdclk,
  output logic       sdo,
  input  logic       sdi,
  output logic [7:0] data,
  output logic       data_stb,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       err_token,
  output logic       crc_err
);

  typedef enum logic [2:0] {IDLE, WAIT_TOKEN, DATA, CRC, FIN} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] FF_LIMIT = 16'(TOKEN_TIMEOUT);

  state_t      state, state_nx;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [15:0] ff_cnt;
  logic [9:0]  byte_cnt;

  logic       running;
  logic       div_wrap;
  logic       rise;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic       accept;
  logic       ff_hit;
  logic       fin_now;

  // The bit clock only runs while bytes are being shifted; FIN just lets the
  // final high half finish.
  assign running   = (state == WAIT_TOKEN) || (state == DATA) || (state == CRC);
  assign div_wrap  = (div_cnt == DIV_LAST);
  assign rise      = running && div_wrap && !sdclk;
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign rx_byte   = {shreg, sdi};
  // A start landing in the done clk sees IDLE already, so done masks it.
  assign accept    = start && (state == IDLE) && !done;
  assign ff_hit    = (ff_cnt + 16'd1) == FF_LIMIT;
  assign fin_now   = (state == FIN) && !sdclk;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic, driven by completed bytes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (accept) state_nx = WAIT_TOKEN;
      WAIT_TOKEN: if (byte_done) begin
                    if (rx_byte == 8'hFE)      state_nx = DATA;
                    else if (rx_byte != 8'hFF) state_nx = FIN;
                    else if (ff_hit)           state_nx = FIN;
                  end
      DATA:       if (byte_done && byte_cnt == 10'd511) state_nx = CRC;
      CRC:        if (byte_done && byte_cnt[0])         state_nx = FIN;
      FIN:        if (!sdclk) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    sdo  = 1'b1;
  end

  // sdclk divider: low half then high half, CLK_DIV clks each
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sdclk   <= 1'b0;
    end else if (state == IDLE || fin_now) begin
      div_cnt <= '0;
      sdclk   <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      sdclk   <= ~sdclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Shift register, byte handling, strobes and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      ff_cnt      <= '0;
      byte_cnt    <= '0;
      data        <= '0;
      data_stb    <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_token   <= 1'b0;
    end else begin
      data_stb <= 1'b0;
      done     <= fin_now;
      if (accept) begin
        bit_cnt     <= '0;
        ff_cnt      <= '0;
        byte_cnt    <= '0;
        err_timeout <= 1'b0;
        err_token   <= 1'b0;
      end
      if (rise) begin
        shreg   <= {shreg[5:0], sdi};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        case (state)
          WAIT_TOKEN: begin
            if (rx_byte == 8'hFE) begin
              byte_cnt <= '0;
            end else if (rx_byte == 8'hFF) begin
              ff_cnt <= ff_cnt + 16'd1;
              if (ff_hit) err_timeout <= 1'b1;
            end else begin
              err_token <= 1'b1;
              data      <= rx_byte;
            end
          end
          DATA: begin
            data     <= rx_byte;
            data_stb <= 1'b1;
            byte_cnt <= byte_cnt + 10'd1;
          end
          CRC:     byte_cnt <= byte_cnt + 10'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef SD_RX_CRC16_EN
  logic [15:0] crc_calc;
  logic [15:0] crc_rx;

  // Running CRC16 over data bits as they arrive; trailer collected and compared at done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_calc <= '0;
      crc_rx   <= '0;
      crc_err  <= 1'b0;
    end else begin
      if (accept) begin
        crc_calc <= '0;
        crc_rx   <= '0;
        crc_err  <= 1'b0;
      end
      if (rise && state == DATA)
        crc_calc <= {crc_calc[14:0], 1'b0} ^ ((crc_calc[15] ^ sdi) ? 16'h1021 : 16'h0000);
      if (rise && state == CRC)
        crc_rx <= {crc_rx[14:0], sdi};
      if (fin_now)
        crc_err <= (crc_calc != crc_rx);
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule
